uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters.
- Grants are packet-locked: a requester keeps the transmitter from its first byte through its byte flagged last.
- The block sequences the transmitter one byte at a time: it issues a start pulse, then waits for completion before fetching the next byte.
- Sits between the requesters (command/response engines) and the UART TX datapath, which mirrors the existing UART RX (dv/data/q style).

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between
// NUM_REQ byte-stream requesters. Each accepted byte is handed to the TX as
// a one-cycle start pulse, and the next byte is fetched only after tx_done.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx_dv,
  output logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_busy,
  input  logic                            tx_done,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] STALL_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state;
  logic [IW-1:0]         gidx;
  logic [IW-1:0]         rr_ptr;
  logic [CW-1:0]         stall_cnt;
  logic                  last_q;

  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic [IW-1:0]         cand;
  logic [IW-1:0]         next_ptr;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;

  // Unpack the flat byte bus so the owner's byte can be picked by index.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign data_arr[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign sel_data  = data_arr[gidx];
  assign sel_valid = req_valid[gidx];
  assign sel_last  = req_last[gidx];

  // A byte is taken only from the owner while in SEND and the TX is free.
  assign accept = (state == SEND) && sel_valid && !tx_busy;

  // Pointer advances past the owner, wrapping for any NUM_REQ.
  assign next_ptr = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Ready goes only to the owner, and only on the cycle a byte is accepted.
  always_comb begin
    req_ready       = '0;
    req_ready[gidx] = accept;
  end

  // Arbitration and TX sequencing state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      rr_ptr      <= '0;
      stall_cnt   <= '0;
      last_q      <= 1'b0;
      tx_dv       <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_dv       <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            gidx      <= pick_idx;
            grant     <= NUM_REQ'(1) << pick_idx;
            stall_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          // tx_done arriving here belongs to no pending byte and is ignored.
          if (accept) begin
            tx_data   <= sel_data;
            tx_dv     <= 1'b1;
            last_q    <= sel_last;
            stall_cnt <= '0;
            state     <= WAIT;
          end else if (stall_cnt == STALL_MAX) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            rr_ptr      <= next_ptr;
            stall_cnt   <= '0;
            state       <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (last_q) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              state  <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a stub UART TX that stays busy for
// ten cycles after each start pulse and then pulses tx_done.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic            tx_dv;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic            tx_done;
  logic [NR-1:0]   grant;
  logic            timeout_err;

  logic            stub_busy = 1'b0;
  logic            stub_done = 1'b0;
  logic            force_busy = 1'b0;
  int unsigned     stub_cnt = 0;

  int unsigned     n_vec = 0;
  int unsigned     n_err = 0;

  // Requester packet stores: bit 8 = last, bits 7:0 = data.
  logic [8:0]      pkt [NR][4];
  int unsigned     plen [NR] = '{default: 0};
  int unsigned     pidx [NR] = '{default: 0};
  logic [NR-1:0]   acc = '0;

  // Transmit log captured on every tx_dv.
  logic [3:0]      log_g [32];
  logic [7:0]      log_d [32];
  int unsigned     n_log = 0;
  int unsigned     n_dv = 0;
  int unsigned     n_done = 0;
  int unsigned     n_to = 0;

  logic [3:0]      rr_g [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [7:0]      rr_d [8] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3};

  assign tx_busy = stub_busy | force_busy;
  assign tx_done = stub_done;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_dv      (tx_dv),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Stub UART TX: busy for 10 cycles after a start pulse, then tx_done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy <= 1'b0;
      stub_done <= 1'b0;
      stub_cnt  <= 0;
    end else begin
      stub_done <= 1'b0;
      if (tx_dv) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 10;
      end else if (stub_cnt > 1) begin
        stub_cnt <= stub_cnt - 1;
      end else if (stub_cnt == 1) begin
        stub_cnt  <= 0;
        stub_busy <= 1'b0;
        stub_done <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (pidx[i] < plen[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = pkt[i][pidx[i]][7:0];
        req_last[i]           = pkt[i][pidx[i]][8];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      plen[i] = 0;
      pidx[i] = 0;
    end
    drive_reqs();
  endtask

  task automatic wait_grant(input logic [3:0] exp, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (grant !== exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(grant), 32'(exp));
  endtask

  task automatic wait_log(input int unsigned cnt, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (n_log < cnt && n < budget) begin
      tick();
      n++;
    end
    check(tag, n_log, cnt);
  endtask

  // Requester side: advance a store when its byte was accepted on the edge.
  initial begin
    forever begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      if (rst_n) begin
        for (int i = 0; i < NR; i++) begin
          if (acc[i]) pidx[i]++;
        end
      end
      drive_reqs();
    end
  end

  // Monitor: log every start pulse and count done/timeout events.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_dv) begin
        if (n_log < 32) begin
          log_g[n_log] = grant;
          log_d[n_log] = tx_data;
        end
        n_log++;
        n_dv++;
      end
      if (tx_done)     n_done++;
      if (timeout_err) n_to++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got n_vec=%0d, required completion", n_vec);
    $fatal(1);
  end

  initial begin
    int unsigned n;

    // Reset state, with all requesters valid during reset.
    #2;
    req_valid = '1;
    #1;
    check("rst_ready", 32'(req_ready), 'h0);
    check("rst_grant", 32'(grant), 'h0);
    check("rst_dv", 32'(tx_dv), 'h0);
    check("rst_data", 32'(tx_data), 'h0);
    check("rst_to", 32'(timeout_err), 'h0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_grant", 32'(grant), 'h0);

    // Single requester: req1 sends 0xA5 (last).
    pkt[1][0] = {1'b1, 8'hA5};
    plen[1] = 1;
    pidx[1] = 0;
    drive_reqs();
    tick();
    check("t1_grant", 32'(grant), 'b0010);
    check("t1_ready", 32'(req_ready), 'b0010);
    check("t1_dv_early", 32'(tx_dv), 'h0);
    tick();
    check("t1_dv", 32'(tx_dv), 'h1);
    check("t1_data", 32'(tx_data), 'hA5);
    check("t1_ready_wait", 32'(req_ready), 'h0);
    tick();
    check("t1_dv_pulse", 32'(tx_dv), 'h0);
    wait_grant(4'b0000, 40, "t1_idle");
    check("t1_data_hold", 32'(tx_data), 'hA5);

    // Stall timeout: rr_ptr is 2, so req3 wins; it sends a non-last byte and drops.
    pkt[3][0] = {1'b0, 8'h3C};
    plen[3] = 1;
    pidx[3] = 0;
    drive_reqs();
    tick();
    check("t2_grant", 32'(grant), 'b1000);
    tick();
    check("t2_dv", 32'(tx_dv), 'h1);
    check("t2_data", 32'(tx_data), 'h3C);
    n = 0;
    while (!tx_done && n < 40) begin
      tick();
      n++;
    end
    check("t2_done", 32'(tx_done), 'h1);
    tick();
    check("t2_resend_grant", 32'(grant), 'b1000);
    check("t2_resend_ready", 32'(req_ready), 'h0);
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    check("t2_to_cycles", n, 16);
    check("t2_to_grant", 32'(grant), 'h0);
    tick();
    check("t2_to_pulse", 32'(timeout_err), 'h0);

    // Packet lock: req0 sends 3 bytes while req2 waits; rr_ptr wrapped to 0.
    pkt[0][0] = {1'b0, 8'h11};
    pkt[0][1] = {1'b0, 8'h22};
    pkt[0][2] = {1'b1, 8'h33};
    plen[0] = 3;
    pidx[0] = 0;
    pkt[2][0] = {1'b1, 8'h44};
    plen[2] = 1;
    pidx[2] = 0;
    n_log = 0;
    drive_reqs();
    tick();
    check("t3_grant", 32'(grant), 'b0001);
    wait_log(4, 200, "t3_count");
    wait_grant(4'b0000, 40, "t3_idle");
    check("t3_g0", 32'(log_g[0]), 'b0001);
    check("t3_d0", 32'(log_d[0]), 'h11);
    check("t3_g1", 32'(log_g[1]), 'b0001);
    check("t3_d1", 32'(log_d[1]), 'h22);
    check("t3_g2", 32'(log_g[2]), 'b0001);
    check("t3_d2", 32'(log_d[2]), 'h33);
    check("t3_g3", 32'(log_g[3]), 'b0100);
    check("t3_d3", 32'(log_d[3]), 'h44);

    // tx_busy held on entry to SEND: rr_ptr is 3, req1 is the only requester.
    force_busy = 1'b1;
    pkt[1][0] = {1'b1, 8'h5A};
    plen[1] = 1;
    pidx[1] = 0;
    drive_reqs();
    tick();
    check("t4_grant", 32'(grant), 'b0010);
    for (int k = 0; k < 3; k++) begin
      check("t4_ready_busy", 32'(req_ready), 'h0);
      check("t4_dv_busy", 32'(tx_dv), 'h0);
      tick();
    end
    force_busy = 1'b0;
    #1;
    check("t4_ready_free", 32'(req_ready), 'b0010);
    check("t4_dv_free", 32'(tx_dv), 'h0);
    tick();
    check("t4_dv", 32'(tx_dv), 'h1);
    check("t4_data", 32'(tx_data), 'h5A);
    wait_grant(4'b0000, 40, "t4_idle");

    // Reset mid-packet: rr_ptr is 2, req2 starts a 2-byte packet.
    pkt[2][0] = {1'b0, 8'h77};
    pkt[2][1] = {1'b1, 8'h88};
    plen[2] = 2;
    pidx[2] = 0;
    drive_reqs();
    tick();
    check("t5_grant", 32'(grant), 'b0100);
    tick();
    check("t5_dv", 32'(tx_dv), 'h1);
    check("t5_data", 32'(tx_data), 'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_grant", 32'(grant), 'h0);
    check("t5_rst_dv", 32'(tx_dv), 'h0);
    check("t5_rst_data", 32'(tx_data), 'h0);
    check("t5_rst_ready", 32'(req_ready), 'h0);
    clear_reqs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_idle", 32'(grant), 'h0);

    // Round robin: all four continuously valid with two 1-byte packets each.
    for (int i = 0; i < NR; i++) begin
      pkt[i][0] = {1'b1, 4'hC, 4'(i)};
      pkt[i][1] = {1'b1, 4'hD, 4'(i)};
      plen[i] = 2;
      pidx[i] = 0;
    end
    n_log  = 0;
    n_dv   = 0;
    n_done = 0;
    drive_reqs();
    tick();
    check("t6_first", 32'(grant), 'b0001);
    wait_log(8, 300, "t6_count");
    wait_grant(4'b0000, 40, "t6_idle");
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t6_g%0d", k), 32'(log_g[k]), 32'(rr_g[k]));
      check($sformatf("t6_d%0d", k), 32'(log_d[k]), 32'(rr_d[k]));
    end
    check("t6_dv_count", n_dv, 8);
    check("t6_done_count", n_done, 8);
    check("total_timeouts", n_to, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
